// File: rtl/sha256_multi_transform.sv
// Multi-lane SHA-256/224 block engine sharing one iterative core.
// Round-robin block arbitration, per-lane chaining values.
module sha256_multi_transform #(
  parameter int LANES = 4,
  parameter int ROUNDS_PER_CYCLE = 1,
  parameter bit SHA224_EN = 1,
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [LANES-1:0]   blk_vld,
  output logic [LANES-1:0]   blk_rdy,
  input  logic [LANES*512-1:0] blk_data,
  input  logic [LANES-1:0]   blk_first,
  input  logic [LANES-1:0]   blk_last,
  input  logic [LANES-1:0]   blk_sha224,
  output logic               hash_vld,
  input  logic               hash_rdy,
  output logic [255:0]       hash,
  output logic [LW-1:0]      hash_lane
);

  typedef enum logic [1:0] {
    S_IDLE, S_ROUND, S_FINAL, S_OUT
  } state_t;

  localparam int R = ROUNDS_PER_CYCLE;
  localparam logic [5:0] LAST_RND = 6'(64 - R);

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] IV256 [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] IV224 [8] = '{
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
  };

  function automatic logic [31:0] rotr(
    input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bs0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bs1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ss0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ss1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  state_t state, nxt;
  logic [LW-1:0] ptr, cur, gidx, ix;
  logic [5:0] rnd, kix;
  logic cur_last, any, acc, sel;
  logic [LANES-1:0] grant, mode;
  logic [31:0] cv [LANES][8];
  logic [31:0] v [8];
  logic [31:0] vn [8];
  logic [31:0] sum [8];
  logic [31:0] ivsel [8];
  logic [31:0] w [16];
  logic [31:0] wn [16];
  logic [31:0] t1, t2, nw;
  logic [511:0] blks [LANES];
  logic [511:0] sblk;
  logic [255:0] hash_q;
  logic vld_q;
  logic [LW-1:0] lane_q;

  for (genvar i = 0; i < LANES; i++) begin : g_split
    assign blks[i] = blk_data[i*512 +: 512];
  end

  // Round-robin pick of the first valid lane from the pointer
  always_comb begin
    grant = '0;
    gidx = '0;
    any = 1'b0;
    ix = '0;
    for (int k = 0; k < LANES; k++) begin
      ix = LW'((int'(ptr) + k) % LANES);
      if (!any && blk_vld[ix]) begin
        any = 1'b1;
        gidx = ix;
      end
    end
    if (any) grant[gidx] = 1'b1;
  end

  assign blk_rdy = (rst_n && state == S_IDLE) ? grant : '0;
  assign acc = (state == S_IDLE) && any;
  assign sel = SHA224_EN && blk_sha224[gidx];
  assign sblk = blks[gidx];

  // IV choice and FINAL feed-forward sum
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      ivsel[i] = sel ? IV224[i] : IV256[i];
      sum[i] = cv[cur][i] + v[i];
    end
  end

  // Unrolled round group with rolling schedule window
  always_comb begin
    for (int i = 0; i < 8; i++) vn[i] = v[i];
    for (int j = 0; j < 16; j++) wn[j] = w[j];
    t1 = '0;
    t2 = '0;
    nw = '0;
    kix = '0;
    for (int r = 0; r < R; r++) begin
      kix = rnd + 6'(r);
      t1 = vn[7] + bs1(vn[4])
         + ((vn[4] & vn[5]) ^ (~vn[4] & vn[6]))
         + K[kix] + wn[0];
      t2 = bs0(vn[0])
         + ((vn[0] & vn[1]) ^ (vn[0] & vn[2])
         ^ (vn[1] & vn[2]));
      vn[7] = vn[6];
      vn[6] = vn[5];
      vn[5] = vn[4];
      vn[4] = vn[3] + t1;
      vn[3] = vn[2];
      vn[2] = vn[1];
      vn[1] = vn[0];
      vn[0] = t1 + t2;
      nw = ss1(wn[14]) + wn[9] + ss0(wn[1]) + wn[0];
      for (int j = 0; j < 15; j++) wn[j] = wn[j+1];
      wn[15] = nw;
    end
  end

  // Core state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else state <= nxt;
  end

  // Core next-state logic
  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:  if (acc) nxt = S_ROUND;
      S_ROUND: if (rnd == LAST_RND) nxt = S_FINAL;
      S_FINAL: nxt = cur_last ? S_OUT : S_IDLE;
      S_OUT:   if (hash_rdy) nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // Datapath: capture, rounds, chaining write-back, digest
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
      cur <= '0;
      rnd <= '0;
      cur_last <= 1'b0;
      mode <= '0;
      vld_q <= 1'b0;
      hash_q <= '0;
      lane_q <= '0;
      for (int l = 0; l < LANES; l++)
        for (int i = 0; i < 8; i++) cv[l][i] <= IV256[i];
      for (int i = 0; i < 8; i++) v[i] <= '0;
      for (int j = 0; j < 16; j++) w[j] <= '0;
    end else begin
      unique case (state)
        S_IDLE: if (acc) begin
          ptr <= LW'((int'(gidx) + 1) % LANES);
          cur <= gidx;
          cur_last <= blk_last[gidx];
          rnd <= '0;
          for (int j = 0; j < 16; j++)
            w[j] <= sblk[511-32*j -: 32];
          if (blk_first[gidx]) begin
            mode[gidx] <= sel;
            for (int i = 0; i < 8; i++) begin
              cv[gidx][i] <= ivsel[i];
              v[i] <= ivsel[i];
            end
          end else begin
            for (int i = 0; i < 8; i++) v[i] <= cv[gidx][i];
          end
        end
        S_ROUND: begin
          for (int i = 0; i < 8; i++) v[i] <= vn[i];
          for (int j = 0; j < 16; j++) w[j] <= wn[j];
          rnd <= rnd + 6'(R);
        end
        S_FINAL: begin
          for (int i = 0; i < 8; i++) cv[cur][i] <= sum[i];
          if (cur_last) begin
            vld_q <= 1'b1;
            lane_q <= cur;
            hash_q <= {sum[0], sum[1], sum[2], sum[3],
                       sum[4], sum[5], sum[6],
                       mode[cur] ? 32'h0 : sum[7]};
          end
        end
        S_OUT: if (hash_rdy) vld_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign hash_vld = vld_q;
  assign hash = hash_q;
  assign hash_lane = lane_q;

endmodule

// File: doc/sha256_multi_transform.md
# sha256_multi_transform

Multi-lane, parametrised SHA-256/SHA-224 block engine. Up to LANES independent message streams share one iterative compression core that computes ROUNDS_PER_CYCLE rounds per clock. The core arbitrates round-robin between lanes at block granularity. It keeps a per-lane chaining value and computes the message schedule internally with a rolling 16-word window. It sits between the padding/packing front end and the hash-result consumer, in place of the single-stream transform.

## Interface
- LANES, 4: number of independent message streams, 1..8.
- ROUNDS_PER_CYCLE, 1: unrolled rounds per clock. Legal values are 1, 2, 4.
- SHA224_EN, 1: 1 enables the SHA-224 mode input. 0 ties the mode to SHA-256.
- clk  in  1  clock. All state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- blk_vld  in  LANES  per-lane block valid.
- blk_rdy  out  LANES  per-lane block ready.
- blk_data  in  LANES×512  per-lane block. Bits [511:480] hold W0, big-endian words, down to bits [31:0] holding W15.
- blk_first  in  LANES  block starts a new message. The chaining value is loaded from the IV.
- blk_last  in  LANES  final block of the message. Produces a digest.
- blk_sha224  in  LANES  mode bit. Sampled only with blk_first; ignored when SHA224_EN=0.
- hash_vld  out  1  digest valid.
- hash_rdy  in  1  digest accepted.
- hash  out  256  digest. H0 sits in bits [255:224]. In SHA-224 mode the digest is H0..H6 in bits [255:32] and bits [31:0] are 0.
- hash_lane  out  $clog2(LANES) (min 1)  lane that produced hash.

## Operation
- Core FSM states:
  - IDLE: arbitrate. On a grant, capture the block, lane id, first/last flags and working vars a..h, then go to ROUND.
  - ROUND: perform ROUNDS_PER_CYCLE rounds per cycle. A round counter counts 0..63 in steps of ROUNDS_PER_CYCLE. After the last group, go to FINAL.
  - FINAL: add the working vars to the chaining value, mod 2^32 per word, and write the result back to that lane's chaining register. If not last, go to IDLE. If last, load the output register and go to OUT.
  - OUT: hold hash_vld=1 until hash_rdy, then go to IDLE.
- Arbitration:
  - blk_rdy[i] = (state==IDLE) & grant[i].
  - grant is one-hot, round-robin over blk_vld, starting at the pointer.
  - The pointer moves to (granted lane + 1) mod LANES on each accept. Its reset value is 0.
  - Only one lane is accepted per IDLE cycle.
- Chaining value:
  - On blk_first, the working vars and the base for the FINAL add come from the IV. The IV is the SHA-256 IV, or the SHA-224 IV if blk_sha224=1 and SHA224_EN=1.
  - On a non-first block, the base is the stored chaining value of that lane.
  - The mode bit is stored per lane and sampled only with blk_first.
- Schedule:
  - For t<16, W[t] = block word t.
  - For t≥16, W[t] = σ1(W[t-2]) + W[t-7] + σ0(W[t-15]) + W[t-16], computed in a 16-entry shift window.
  - The K constants are indexed by the round number.
- blk_first=blk_last=1 is a single-block message.
- A lane that sends a non-first block with no prior message uses its reset chaining value, which is the SHA-256 IV.
- Interleaving: blocks from different lanes may interleave freely. Each lane's chain is isolated.

## Timing
- Reset values: blk_rdy=0 while rst_n=0. hash_vld=0, hash=0, hash_lane=0. FSM in IDLE. All chaining values = SHA-256 IV, all modes = SHA-256, RR pointer = 0.
- Let N = 64/ROUNDS_PER_CYCLE. An accept at edge T gives:
  - ROUND during cycles T+1..T+N.
  - FINAL in cycle T+N+1.
  - hash_vld=1 from T+N+2 if the block is last.
  - For a non-last block, the next accept is possible at edge T+N+2.
- Throughput per block is N+2 cycles, plus the time spent in OUT under back-pressure.
- hash, hash_lane and hash_vld are stable while hash_vld=1 and hash_rdy=0.
- The core is blocked while in OUT. blk_rdy stays all 0 until the hash is taken.
- If hash_vld=hash_rdy=1 at edge E, hash_vld=0 after E and the next accept is possible at edge E+1.
- blk_rdy may depend combinationally on blk_vld. blk_vld must not depend on blk_rdy.
- Asserting rst_n mid-operation aborts any block in flight, drops any pending digest, and restores every register to its reset value immediately.

## Test plan
- Lane 0, "abc" single block (first=last=1, SHA-256) -> hash = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad, hash_lane=0, hash_vld at accept+N+2.
- Lane 1, same block with blk_sha224=1 -> hash[255:32] = 23097d22 3405d822 8642a477 bda255b3 2aadbce4 bda0b3f7 e36c9da7, hash[31:0]=0.
- Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" on lane 2 interleaved with the empty-message block on lane 3 -> lane 2 gives 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1, and lane 3 gives e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- All four lanes hold vld continuously -> grants in order 0,1,2,3,0…; no lane is starved; per-lane digests are correct.
- hash_rdy held 0 for 20 cycles -> hash stable, blk_rdy=0 throughout; the next accept comes one cycle after the handshake.
- rst_n pulsed low during ROUND -> hash_vld stays 0 and all outputs are at reset values. A fresh "abc" afterwards gives the correct digest.
- Run every scenario at ROUNDS_PER_CYCLE = 1, 2 and 4.
